multicycle_control: RTL and testbench

Multicycle main control unit for the MIPS datapath. A Moore state machine, with memory-handshake qualification, walks each instruction through fetch, decode, execute, memory and writeback steps. Each cycle it drives the datapath mux/enable signals plus the `ALUop`/`addi` pair consumed by the downstream ALU control unit. It sits between the instruction register's opcode field and the datapath/ALU control.

---
 rtl/mips_ctrl_pkg.sv | 72 +++++++
 rtl/mc_output_decode.sv | 81 ++++++++
 rtl/multicycle_control.sv | 95 +++++++++
 tb/tb_multicycle_control.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, state/ALUop/mux encodings and control vector shared by the MIPS control path.
// Honours MC_JUMP_EN (j opcode counted as legal only when defined).
`default_nettype none

package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_SHIMM = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       alu_src_a;
      logic       reg_write;
      logic       reg_dst;
      logic       addi;
      logic [1:0] pc_source;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal;
   } ctrl_t;

   function automatic logic opcode_legal(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: return 1'b1;
`ifdef MC_JUMP_EN
         OP_J: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/mc_output_decode.sv
// mc_output_decode: combinational state -> datapath control vector (Moore, except FETCH IR/PC writes).
// Honours MC_JUMP_EN (JUMP decode present only when defined).
`default_nettype none

module mc_output_decode
   import mips_ctrl_pkg::*;
(
   input  state_t      state,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   output ctrl_t       ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            // IR and PC may only latch once the instruction word has actually arrived
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_SHIMM;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.illegal   = ~opcode_legal(opcode);
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_FUNCT;
            ctrl.addi      = 1'b1;
         end
         S_ADDIWB: begin
            ctrl.reg_write = 1'b1;
         end
`ifdef MC_JUMP_EN
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
`endif
         default: ctrl = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS main control FSM with memory-handshake stalls.
// Build option MC_JUMP_EN enables the j instruction / JUMP state.
`default_nettype none

module multicycle_control
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       addi,
   output logic [1:0] PCSource,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUop,
   output logic       illegal,
   output logic [3:0] state
);

   state_t cur_state;
   state_t nxt_state;
   ctrl_t  dec_ctrl;
   ctrl_t  ctrl;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur_state <= S_FETCH;
      else       cur_state <= nxt_state;
   end

   always_comb begin
      nxt_state = S_FETCH;
      case (cur_state)
         S_FETCH:  nxt_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: nxt_state = S_MEMADR;
               OP_RTYPE:     nxt_state = S_EXEC;
               OP_BEQ:       nxt_state = S_BRANCH;
               OP_ADDI:      nxt_state = S_ADDIEX;
`ifdef MC_JUMP_EN
               OP_J:         nxt_state = S_JUMP;
`endif
               default:      nxt_state = S_FETCH;
            endcase
         end
         // IR still holds the opcode here, so lw/sw can be told apart again
         S_MEMADR: nxt_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  nxt_state = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   nxt_state = S_ALUWB;
         S_ADDIEX: nxt_state = S_ADDIWB;
         default:  nxt_state = S_FETCH;
      endcase
   end

   mc_output_decode u_decode (
      .state     (cur_state),
      .opcode    (opcode),
      .mem_ready (mem_ready),
      .ctrl      (dec_ctrl)
   );

   // Reset blanks every output combinationally so no write enable survives an abort
   assign ctrl  = reset ? '0 : dec_ctrl;
   assign state = reset ? 4'd0 : cur_state;

   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign IorD        = ctrl.iord;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign IRWrite     = ctrl.ir_write;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign RegWrite    = ctrl.reg_write;
   assign RegDst      = ctrl.reg_dst;
   assign addi        = ctrl.addi;
   assign PCSource    = ctrl.pc_source;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign ALUop       = ctrl.alu_op;
   assign illegal     = ctrl.illegal;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed + random bench for multicycle_control against an instruction-step model.
// Honours MC_JUMP_EN for the j-opcode expectations.
`default_nettype none

module tb_multicycle_control;

   localparam logic [5:0] T_R    = 6'b000000;
   localparam logic [5:0] T_LW   = 6'b100011;
   localparam logic [5:0] T_SW   = 6'b101011;
   localparam logic [5:0] T_BEQ  = 6'b000100;
   localparam logic [5:0] T_ADDI = 6'b001000;
   localparam logic [5:0] T_J    = 6'b000010;
   localparam logic [5:0] T_BAD  = 6'b111111;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
   logic       ALUSrcA, RegWrite, RegDst, addi, illegal;
   logic [1:0] PCSource, ALUSrcB, ALUop;
   logic [3:0] state;

   int total = 0;
   int bad   = 0;

   multicycle_control dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .mem_ready   (mem_ready),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .MemtoReg    (MemtoReg),
      .IRWrite     (IRWrite),
      .ALUSrcA     (ALUSrcA),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .addi        (addi),
      .PCSource    (PCSource),
      .ALUSrcB     (ALUSrcB),
      .ALUop       (ALUop),
      .illegal     (illegal),
      .state       (state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model: instruction = list of steps after DECODE
   int m_state;
   int m_q[$];

   function automatic logic legal(input logic [5:0] op);
      if (op == T_R || op == T_LW || op == T_SW || op == T_BEQ || op == T_ADDI) return 1'b1;
`ifdef MC_JUMP_EN
      if (op == T_J) return 1'b1;
`endif
      return 1'b0;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_state = 0;
         m_q.delete();
      end else if (m_state == 0) begin
         if (mem_ready) m_state = 1;
      end else if (m_state == 1) begin
         m_q.delete();
         if (opcode == T_LW)        begin m_q.push_back(2); m_q.push_back(3); m_q.push_back(4); end
         else if (opcode == T_SW)   begin m_q.push_back(2); m_q.push_back(5); end
         else if (opcode == T_R)    begin m_q.push_back(6); m_q.push_back(7); end
         else if (opcode == T_BEQ)  m_q.push_back(8);
         else if (opcode == T_ADDI) begin m_q.push_back(9); m_q.push_back(10); end
`ifdef MC_JUMP_EN
         else if (opcode == T_J)    m_q.push_back(11);
`endif
         m_state = (m_q.size() > 0) ? m_q.pop_front() : 0;
      end else if (!((m_state == 3 || m_state == 5) && !mem_ready)) begin
         m_state = (m_q.size() > 0) ? m_q.pop_front() : 0;
      end
   end

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,addi,PCSource,ALUSrcB,ALUop,illegal}
   function automatic logic [17:0] exp_ctrl(input int s, input logic [5:0] op, input logic mr);
      logic pcw, pcwc, iord, mrd, mwr, m2r, irw, sa, rw, rd, ad, il;
      logic [1:0] pcs, sb, ao;
      pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; m2r = 0; irw = 0;
      sa = 0; rw = 0; rd = 0; ad = 0; il = 0; pcs = 0; sb = 0; ao = 0;
      case (s)
         0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
         1:  begin sb = 2'b11; il = ~legal(op); end
         2:  begin sa = 1; sb = 2'b10; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; iord = 1; end
         6:  begin sa = 1; ao = 2'b10; end
         7:  begin rw = 1; rd = 1; end
         8:  begin sa = 1; ao = 2'b01; pcwc = 1; pcs = 2'b01; end
         9:  begin sa = 1; sb = 2'b10; ao = 2'b10; ad = 1; end
         10: rw = 1;
         11: begin pcw = 1; pcs = 2'b10; end
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, m2r, irw, sa, rw, rd, ad, pcs, sb, ao, il};
   endfunction

   function automatic logic [17:0] act_ctrl();
      return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
              RegWrite, RegDst, addi, PCSource, ALUSrcB, ALUop, illegal};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: act=0x%0h exp=0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_model();
      logic [17:0] e;
      e = reset ? 18'd0 : exp_ctrl(m_state, opcode, mem_ready);
      chk("ctrl", {14'd0, act_ctrl()}, {14'd0, e});
      chk("state", {28'd0, state}, reset ? 32'd0 : m_state);
   endtask

   task automatic step(input logic r, input logic mr, input logic [5:0] op);
      @(posedge clk);
      #1;
      reset = r; mem_ready = mr; opcode = op;
      @(negedge clk);
      cmp_model();
   endtask

   int sts[10];
   int wcount;
   logic [5:0] rop;
   logic [5:0] choices[8];

   initial begin
      reset = 1'b1; mem_ready = 1'b0; opcode = T_R;
      step(1, 0, T_R);
      step(1, 1, T_R);
      chk("rst_state", {28'd0, state}, 32'd0);
      chk("rst_ctrl", {14'd0, act_ctrl()}, 32'd0);

      // R-type into EXEC, then abort with reset
      step(0, 1, T_R);
      step(0, 1, T_R);
      step(0, 1, T_R);
      chk("exec_state", {28'd0, state}, 32'd6);
      reset = 1'b1;
      #1;
      chk("abort_ctrl", {14'd0, act_ctrl()}, 32'd0);
      chk("abort_state", {28'd0, state}, 32'd0);
      step(1, 0, T_R);

      // lw with memory always ready
      for (int i = 0; i < 5; i++) begin
         step(0, 1, T_LW);
         sts[i] = int'(state);
         if (i == 4) chk("memwb_rw_m2r_rd", {29'd0, RegWrite, MemtoReg, RegDst}, 32'b110);
      end
      chk("lw_seq", {sts[0][3:0], sts[1][3:0], sts[2][3:0], sts[3][3:0], sts[4][3:0]}, 32'h01234);

      // sw: 2 fetch stalls, 3 write stalls
      wcount = 0;
      for (int i = 0; i < 9; i++) begin
         logic mr;
         mr = !(i == 0 || i == 1 || i == 5 || i == 6 || i == 7);
         step(0, mr, T_SW);
         sts[i] = int'(state);
         if (i < 2) chk("fetch_stall_irw_pcw", {30'd0, IRWrite, PCWrite}, 32'b00);
         if (i == 2) chk("fetch_ready_irw_pcw", {30'd0, IRWrite, PCWrite}, 32'b11);
         if (MemWrite) wcount++;
      end
      chk("sw_memwrite_cycles", wcount, 32'd4);
      chk("sw_seq", {sts[0][3:0], sts[1][3:0], sts[2][3:0], sts[3][3:0], sts[4][3:0],
                     sts[5][3:0], sts[6][3:0], sts[8][3:0]}, 32'h00012555);

      // beq: returns to FETCH on the 4th step
      step(0, 1, T_BEQ);
      chk("sw_done", {28'd0, state}, 32'd0);
      step(0, 1, T_BEQ);
      step(0, 1, T_BEQ);
      chk("beq_state", {28'd0, state}, 32'd8);
      chk("beq_ctrl", {25'd0, ALUop, PCWriteCond, PCSource, ALUSrcA}, {25'd0, 2'b01, 1'b1, 2'b01, 1'b1});

      // R-type
      step(0, 1, T_R);
      chk("beq_done", {28'd0, state}, 32'd0);
      step(0, 1, T_R);
      step(0, 1, T_R);
      chk("exec_aluop_addi", {29'd0, ALUop, addi}, 32'b100);
      step(0, 1, T_R);
      chk("aluwb_state_rd", {27'd0, state, RegDst}, {27'd0, 4'd7, 1'b1});

      // addi
      step(0, 1, T_ADDI);
      step(0, 1, T_ADDI);
      step(0, 1, T_ADDI);
      chk("addiex", {23'd0, state, ALUop, addi, ALUSrcB}, {23'd0, 4'd9, 2'b10, 1'b1, 2'b10});
      step(0, 1, T_ADDI);
      chk("addiwb", {27'd0, state, RegDst}, {27'd0, 4'd10, 1'b0});

      // j
      step(0, 1, T_J);
      step(0, 1, T_J);
`ifdef MC_JUMP_EN
      chk("j_decode_illegal", {31'd0, illegal}, 32'd0);
      step(0, 1, T_J);
      chk("jump", {25'd0, state, PCWrite, PCSource}, {25'd0, 4'd11, 1'b1, 2'b10});
`else
      chk("j_decode_illegal", {27'd0, state, illegal}, {27'd0, 4'd1, 1'b1});
`endif

      // undefined opcode
      step(0, 1, T_BAD);
      chk("after_j_fetch", {28'd0, state}, 32'd0);
      step(0, 1, T_BAD);
      chk("bad_illegal", {27'd0, state, illegal}, {27'd0, 4'd1, 1'b1});
      step(0, 1, T_R);
      chk("bad_to_fetch", {27'd0, state, illegal}, 32'd0);

      // randomized traffic, opcode only changes between instructions
      choices[0] = T_R;   choices[1] = T_LW;   choices[2] = T_SW; choices[3] = T_BEQ;
      choices[4] = T_ADDI; choices[5] = T_J;   choices[6] = T_BAD; choices[7] = 6'b000000;
      rop = T_R;
      for (int n = 0; n < 3000; n++) begin
         logic r, mr;
         if (m_state == 0) begin
            int k;
            k = int'($urandom_range(0, 8));
            rop = (k == 8) ? 6'($urandom) : choices[k];
         end
         r  = ($urandom_range(0, 99) == 0);
         mr = ($urandom_range(0, 3) != 0);
         step(r, mr, rop);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
